legv8_mc_control: RTL and testbench

Multi-cycle control sequencer for the 64-bit LEGv8 datapath. It fetches an instruction over a valid/ready handshake, decodes the 11-bit opcode, and sequences the execute stage (AluSrc, AluControl, zero_E), data memory and register-file writeback over several cycles. It replaces the single-cycle combinational control when the execute stage and memory are shared across cycles. It also tracks retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/legv8_mc_control.sv | 189 ++++++++++++++++++
 tb/tb_legv8_mc_control.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 control sequencer: fetch handshake, decode, execute, memory and
// writeback sequencing with a retired-instruction counter and sticky fault detection.
module legv8_mc_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int RET_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [10:0]      Op,
   input  logic             zero_E,
   input  logic             mem_ready,
   output logic             Reg2Loc,
   output logic             AluSrc,
   output logic [3:0]       AluControl,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             fault,
   output logic [RET_W-1:0] retired
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LP_CNT_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_FAULT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [10:0]      r_op;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic [RET_W-1:0] r_retired;
   logic             w_retire;
   logic             w_fire;

   logic w_ldur, w_stur, w_cbz, w_add, w_sub, w_and, w_orr;
   logic w_rtype, w_memop, w_legal;
   logic [3:0] w_alu_op;

   logic       w_instr_ready, w_reg2loc, w_alusrc, w_memread, w_memwrite;
   logic       w_memtoreg, w_regwrite, w_irwrite, w_pcwrite, w_pcsrc, w_fault;
   logic [3:0] w_aluctl;

   assign w_ldur  = (r_op == 11'b11111000010);
   assign w_stur  = (r_op == 11'b11111000000);
   assign w_cbz   = (r_op[10:3] == 8'b10110100);
   assign w_add   = (r_op == 11'b10001011000);
   assign w_sub   = (r_op == 11'b11001011000);
   assign w_and   = (r_op == 11'b10001010000);
   assign w_orr   = (r_op == 11'b10101010000);
   assign w_rtype = w_add | w_sub | w_and | w_orr;
   assign w_memop = w_ldur | w_stur;
   assign w_legal = w_rtype | w_memop | w_cbz;

   assign w_alu_op = w_orr ? 4'b0001 :
                     w_sub ? 4'b0110 :
                     w_cbz ? 4'b0111 :
                     (w_add | w_memop) ? 4'b0010 : 4'b0000;

   assign w_fire = (r_state == S_FETCH) && instr_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_FETCH;
         r_op      <= '0;
         r_cnt     <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_fire) begin
            r_op <= Op;
         end
         if (w_retire) begin
            r_retired <= r_retired + RET_W'(1);
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      w_cnt_next    = r_cnt;
      w_retire      = 1'b0;
      w_instr_ready = 1'b0;
      w_reg2loc     = 1'b0;
      w_alusrc      = 1'b0;
      w_aluctl      = 4'b0000;
      w_memread     = 1'b0;
      w_memwrite    = 1'b0;
      w_memtoreg    = 1'b0;
      w_regwrite    = 1'b0;
      w_irwrite     = 1'b0;
      w_pcwrite     = 1'b0;
      w_pcsrc       = 1'b0;
      w_fault       = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_instr_ready = 1'b1;
            if (instr_valid) begin
               w_irwrite = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            w_reg2loc = w_stur | w_cbz;
            w_next    = w_legal ? S_EXEC : S_FAULT;
         end
         S_EXEC: begin
            w_reg2loc = w_stur | w_cbz;
            w_alusrc  = w_memop;
            w_aluctl  = w_alu_op;
            if (w_rtype) begin
               w_next = S_WB;
            end else if (w_memop) begin
               w_cnt_next = '0;
               w_next     = S_MEM;
            end else begin
               w_pcwrite = 1'b1;
               w_pcsrc   = zero_E;
               w_retire  = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_MEM: begin
            w_reg2loc  = w_stur;
            w_alusrc   = 1'b1;
            w_aluctl   = w_alu_op;
            w_memread  = w_ldur;
            w_memwrite = w_stur;
            // A completion on the last allowed cycle takes priority over the timeout.
            if (mem_ready) begin
               if (w_ldur) begin
                  w_next = S_WB;
               end else begin
                  w_pcwrite = 1'b1;
                  w_retire  = 1'b1;
                  w_next    = S_FETCH;
               end
            end else if (r_cnt == LP_CNT_LAST) begin
               w_next = S_FAULT;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_WB: begin
            w_regwrite = 1'b1;
            w_memtoreg = w_ldur;
            w_pcwrite  = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_FAULT: begin
            w_fault = 1'b1;
         end
         default: begin
            w_next = S_FAULT;
         end
      endcase
   end

   // Everything is forced low while reset is held, including the FETCH-state ready.
   assign instr_ready = reset_n & w_instr_ready;
   assign Reg2Loc     = reset_n & w_reg2loc;
   assign AluSrc      = reset_n & w_alusrc;
   assign AluControl  = reset_n ? w_aluctl : 4'b0000;
   assign MemRead     = reset_n & w_memread;
   assign MemWrite    = reset_n & w_memwrite;
   assign MemtoReg    = reset_n & w_memtoreg;
   assign RegWrite    = reset_n & w_regwrite;
   assign IRWrite     = reset_n & w_irwrite;
   assign PCWrite     = reset_n & w_pcwrite;
   assign PCSrc       = reset_n & w_pcsrc;
   assign fault       = reset_n & w_fault;
   assign retired     = r_retired;

endmodule

// File: tb/tb_legv8_mc_control.sv
// Scoreboard bench for legv8_mc_control: randomized instructions, expectations from a
// mnemonic-level model, and an independent per-instruction monitor.
module tb_legv8_mc_control;

   localparam int MEM_TIMEOUT = 16;
   localparam int RET_W       = 4;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             instr_valid;
   logic             instr_ready;
   logic [10:0]      Op;
   logic             zero_E;
   logic             mem_ready;
   logic             Reg2Loc, AluSrc, MemRead, MemWrite, MemtoReg, RegWrite;
   logic             IRWrite, PCWrite, PCSrc, fault;
   logic [3:0]       AluControl;
   logic [RET_W-1:0] retired;

   typedef struct {
      bit         isFault;
      int         lat;
      bit         pcsrc;
      bit         regWr;
      bit         memtoReg;
      logic [3:0] alu;
      bit         aluSrc;
      bit         reg2loc;
      int         rdCyc;
      int         wrCyc;
      int         rwCyc;
      int         ret;
   } exp_t;

   exp_t expQ[$];
   int   nCompared  = 0;
   int   nMismatch  = 0;
   int   expRetired = 0;

   legv8_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .RET_W(RET_W)) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .Op(Op), .zero_E(zero_E), .mem_ready(mem_ready), .Reg2Loc(Reg2Loc), .AluSrc(AluSrc),
      .AluControl(AluControl), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
      .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      nCompared++;
      if (act !== req) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Expected outcome of one instruction from its mnemonic, the zero flag and the
   // number of cycles memory stalls (negative means memory never answers).
   function automatic exp_t model(input logic [10:0] op, input bit z, input int waits);
      exp_t e;
      e = '{default: 0};
      casez (op)
         11'b11111000010: begin
            e.aluSrc = 1; e.alu = 4'b0010;
            if (waits < 0) begin
               e.isFault = 1; e.lat = 4 + MEM_TIMEOUT; e.rdCyc = MEM_TIMEOUT;
            end else begin
               e.lat = 5 + waits; e.rdCyc = waits + 1;
               e.regWr = 1; e.memtoReg = 1; e.rwCyc = 1;
            end
         end
         11'b11111000000: begin
            e.aluSrc = 1; e.alu = 4'b0010; e.reg2loc = 1;
            if (waits < 0) begin
               e.isFault = 1; e.lat = 4 + MEM_TIMEOUT; e.wrCyc = MEM_TIMEOUT;
            end else begin
               e.lat = 4 + waits; e.wrCyc = waits + 1;
            end
         end
         11'b10110100???: begin
            e.lat = 3; e.pcsrc = z; e.alu = 4'b0111; e.reg2loc = 1;
         end
         11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
            e.lat = 4; e.regWr = 1; e.rwCyc = 1;
            e.alu = (op == OP_SUB) ? 4'b0110 : (op == OP_ORR) ? 4'b0001 :
                    (op == OP_AND) ? 4'b0000 : 4'b0010;
         end
         default: begin
            e.isFault = 1; e.lat = 3;
         end
      endcase
      return e;
   endfunction

   // Monitor: follows each instruction from IRWrite to its PCWrite or fault.
   int   cyc = 0;
   int   hs = 0;
   bit   inflight = 0;
   bit   retPending = 0;
   int   retExp = 0;
   int   obsRd, obsWr, obsRw;
   logic [3:0] obsAlu;
   logic obsAluSrc, obsReg2loc;
   exp_t monExp;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         inflight   = 0;
         retPending = 0;
      end else begin
         if (retPending) begin
            checkOutput("retired count", 64'(retired), 64'(retExp));
            retPending = 0;
         end
         if (IRWrite) begin
            checkOutput("IRWrite while busy", 64'(inflight), 0);
            inflight = 1; hs = cyc; obsRd = 0; obsWr = 0; obsRw = 0;
            obsAlu = 4'b0; obsAluSrc = 0; obsReg2loc = 0;
         end
         if (inflight) begin
            if (MemRead)  obsRd++;
            if (MemWrite) obsWr++;
            if (RegWrite) obsRw++;
            if (cyc == hs + 2) begin
               obsAlu = AluControl; obsAluSrc = AluSrc; obsReg2loc = Reg2Loc;
            end
            if (PCWrite || fault) begin
               inflight = 0;
               checkOutput("expected entry available", 64'(expQ.size()), 1);
               if (expQ.size() > 0) begin
                  monExp = expQ.pop_front();
                  checkOutput("fault at completion", 64'(fault), 64'(monExp.isFault));
                  checkOutput("PCWrite at completion", 64'(PCWrite), 64'(!monExp.isFault));
                  checkOutput("latency", 64'(cyc - hs + 1), 64'(monExp.lat));
                  checkOutput("PCSrc", 64'(PCSrc), 64'(monExp.pcsrc));
                  checkOutput("RegWrite at completion", 64'(RegWrite), 64'(monExp.regWr));
                  checkOutput("MemtoReg at completion", 64'(MemtoReg), 64'(monExp.memtoReg));
                  checkOutput("AluControl in EXEC", 64'(obsAlu), 64'(monExp.alu));
                  checkOutput("AluSrc in EXEC", 64'(obsAluSrc), 64'(monExp.aluSrc));
                  checkOutput("Reg2Loc in EXEC", 64'(obsReg2loc), 64'(monExp.reg2loc));
                  checkOutput("MemRead cycles", 64'(obsRd), 64'(monExp.rdCyc));
                  checkOutput("MemWrite cycles", 64'(obsWr), 64'(monExp.wrCyc));
                  checkOutput("RegWrite cycles", 64'(obsRw), 64'(monExp.rwCyc));
                  if (monExp.isFault) begin
                     checkOutput("instr_ready in fault", 64'(instr_ready), 0);
                  end else begin
                     retPending = 1;
                     retExp     = monExp.ret;
                  end
               end
            end
         end else begin
            if (PCWrite || MemRead || MemWrite || RegWrite) begin
               checkOutput("strobe while idle", {60'd0, PCWrite, MemRead, MemWrite, RegWrite}, 0);
            end
            if (fault) begin
               checkOutput("instr_ready in fault", 64'(instr_ready), 0);
            end
         end
      end
   end

   task automatic checkAllZero();
      checkOutput("reset instr_ready", 64'(instr_ready), 0);
      checkOutput("reset IRWrite", 64'(IRWrite), 0);
      checkOutput("reset strobes", {58'd0, MemRead, MemWrite, RegWrite, MemtoReg, PCWrite, PCSrc}, 0);
      checkOutput("reset alu", {58'd0, Reg2Loc, AluSrc, AluControl}, 0);
      checkOutput("reset fault", 64'(fault), 0);
      checkOutput("reset retired", 64'(retired), 0);
   endtask

   task automatic applyReset();
      instr_valid = 0;
      mem_ready   = 0;
      reset_n     = 0;
      #1;
      checkAllZero();
      expRetired = 0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1;
      #1;
      checkOutput("instr_ready after reset", 64'(instr_ready), 1);
      checkOutput("fault after reset", 64'(fault), 0);
      checkOutput("retired after reset", 64'(retired), 0);
   endtask

   // Issues one instruction and drives mem_ready so memory answers after 'waits'
   // stall cycles; abortAt > 0 pulls reset at that cycle instead of completing.
   task automatic applyStimulus(input logic [10:0] op, input bit z, input int waits,
                                input bit hold, input int abortAt);
      exp_t e;
      int   guard;
      guard = 0;
      while (!instr_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!instr_ready) begin
         checkOutput("instr_ready within bound", 64'(instr_ready), 1);
         return;
      end
      e = model(op, z, waits);
      if (!e.isFault) begin
         expRetired = (expRetired + 1) % (1 << RET_W);
      end
      e.ret = expRetired;
      if (abortAt < 0) expQ.push_back(e);
      Op          = op;
      zero_E      = z;
      instr_valid = 1;
      mem_ready   = 1'($urandom);
      for (int c = 1; c <= e.lat; c++) begin
         @(posedge clk); #1;
         if (c == abortAt) begin
            checkOutput("MemRead before abort", 64'(MemRead), 1);
            applyReset();
            return;
         end
         if (!hold || c == e.lat) begin
            instr_valid = 0;
            Op          = 11'($urandom);
         end
         mem_ready = (c >= 3) ? (c - 3 == waits) : 1'($urandom);
      end
   endtask

   logic [10:0] opTab[7] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ};

   initial begin
      logic [10:0] rop;
      reset_n = 0; instr_valid = 0; Op = '0; zero_E = 0; mem_ready = 0;
      applyReset();

      applyStimulus(OP_ADD, 0, 0, 1, -1);
      applyStimulus(OP_LDUR, 0, 3, 0, -1);
      applyStimulus(OP_CBZ | 11'd5, 1, 0, 0, -1);
      applyStimulus(OP_CBZ, 0, 0, 0, -1);
      applyStimulus(OP_STUR, 1, 0, 0, -1);
      applyStimulus(OP_LDUR, 0, MEM_TIMEOUT - 1, 0, -1);

      applyReset();
      repeat (16) applyStimulus(OP_SUB, 0, 0, 0, -1);

      for (int i = 0; i < 40; i++) begin
         rop = opTab[$urandom_range(0, 6)];
         if (rop == OP_CBZ) rop[2:0] = 3'($urandom);
         applyStimulus(rop, 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom), -1);
      end

      applyStimulus(OP_STUR, 0, -1, 0, -1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("fault sticky", 64'(fault), 1);
      checkOutput("instr_ready after timeout", 64'(instr_ready), 0);
      applyReset();

      applyStimulus(11'b00000000000, 0, 0, 0, -1);
      applyReset();
      applyStimulus(11'b11111000011, 0, 0, 0, -1);
      applyReset();

      applyStimulus(OP_LDUR, 0, 10, 0, 5);
      applyStimulus(OP_ADD, 0, 0, 0, -1);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard drained", 64'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

   initial begin
      #1000000;
      nMismatch++;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
